branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: br_valid  input  1  branch instruction present in this stage this cycle.
REQ-004 SHALL have port: br_op  input  3  condition code (NONE, BRN, BRZ, BRNZ, BRP, JMP).
REQ-005 SHALL have port: br_addr  input  8  branch target address.
REQ-006 SHALL have port: IFgn / IFgz  input  1 each  registered N / Z flags from the execute stage.
REQ-007 SHALL have port: NFCR / ZFCR  input  1 each  flag-register write enables from the execute stage, this cycle.
REQ-008 SHALL have port: br_taken  output  1  one-cycle pulse, PC redirect.
REQ-009 SHALL have port: br_target  output  8  registered redirect address, valid when br_taken=1.
REQ-010 SHALL have port: stall  output  1  hold upstream stages.
REQ-011 SHALL have port: flush  output  1  squash fetch/decode contents.

Function
REQ-012 SHALL evaluate conditions as: BRN taken if N=1; BRZ if Z=1; BRNZ if Z=0; BRP if N=0 and Z=0; JMP always; NONE never.
REQ-013 SHALL implement states IDLE, HOLD and FLUSH.
REQ-014 IDLE, br_valid=1, (NFCR|ZFCR)=1, br_op not in {NONE, JMP}: SHALL assert stall combinationally, latch br_op/br_addr and go to HOLD.
REQ-015 HOLD: SHALL evaluate the latched op on the now-updated flags one cycle later; taken -> br_taken pulse and go to FLUSH; not taken -> IDLE.
REQ-015a HOLD: stall SHALL deassert on leaving HOLD.
REQ-016 IDLE, br_valid=1, no flag write pending: SHALL evaluate immediately; taken -> br_taken=1 and br_target=br_addr on the next edge, then FLUSH.
REQ-017 JMP SHALL never stall, whatever NFCR/ZFCR are.
REQ-018 FLUSH SHALL assert flush for exactly 2 cycles (2-bit down-counter) and then return to IDLE.
REQ-019 br_valid during FLUSH SHALL be ignored (squashed instruction): no evaluation, no state change.
REQ-020 br_taken SHALL never be high on two consecutive cycles.
REQ-021 br_target SHALL hold its last value when br_taken=0.
REQ-022 Branch latency: from IDLE, br_valid to br_taken is 1 cycle without hazard and 2 cycles with hazard.

Reset
REQ-023 While rst=0, SHALL force state=IDLE, br_taken=0, br_target=8'h00, stall=0, flush=0 and flush counter=0, asynchronously.
REQ-024 Reset asserted mid-HOLD or mid-FLUSH SHALL abort the operation with no residual pulse after release.
REQ-025 SHALL evaluate nothing on the first edge after reset release unless br_valid=1.

Configuration
REQ-026 With BRANCH_STATS_EN defined, SHALL add output br_count (8 bits).
REQ-026a br_count SHALL increment on every br_taken pulse and saturate at 8'hFF.
REQ-026b br_count SHALL be reset to 0.
REQ-027 Without BRANCH_STATS_EN, br_count and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 The br_op encodings (NONE=0, BRN=1, BRZ=2, BRNZ=3, BRP=4, JMP=5) SHALL be shared in package branch_pkg.
REQ-028a The state encodings and FLUSH_CYCLES=2 SHALL also be in branch_pkg.
REQ-029 Condition logic SHALL be one combinational sub-module, br_cond_eval (inputs op, N, Z; output take), instantiated once.
REQ-029a br_cond_eval SHALL be fed by a mux that selects the live or latched op.
REQ-030 Encodings 6-7 SHALL evaluate as not taken.

Verification
REQ-031 BRZ, br_addr=8'h3C, Z=1, no flag write -> br_taken=1 and br_target=8'h3C next cycle; flush=1 for 2 cycles; stall never asserted.
REQ-032 BRN, N=0, NFCR=1 in the same cycle, new N=1 -> stall for 1 cycle, then br_taken=1.
REQ-033 BRP, N=0, Z=1 -> no br_taken, no flush, state stays IDLE.
REQ-034 JMP 8'h10 followed by BRZ (Z=1) during FLUSH -> exactly one br_taken, target 8'h10.
REQ-035 rst=0 during 2nd FLUSH cycle -> flush=0 immediately; after release no br_taken or flush without br_valid.
REQ-036 BRANCH_STATS_EN: 260 taken JMPs -> br_count=8'hFF.

Source files
------------

// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch-resolution block:
//   - br_op_e     : branch condition codes carried on br_op
//   - state_e     : resolver FSM states
//   - FLUSH_CYCLES: number of cycles flush stays high after a redirect
//   - is_conditional(): true for opcodes that depend on the N/Z flags
// -----------------------------------------------------------------------------
package branch_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_BRN  = 3'd1,
        OP_BRZ  = 3'd2,
        OP_BRNZ = 3'd3,
        OP_BRP  = 3'd4,
        OP_JMP  = 3'd5
    } br_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int         FLUSH_CYCLES   = 2;
    localparam logic [1:0] FLUSH_CNT_LOAD = 2'(FLUSH_CYCLES);

    // Anything other than NONE and JMP reads the flags, so it must wait when
    // the execute stage is rewriting them this cycle. Undefined codes 6-7 are
    // treated like conditional ops here; they resolve as not taken anyway.
    function automatic logic is_conditional(input logic [2:0] op);
        return (op != OP_NONE) && (op != OP_JMP);
    endfunction

endpackage

// File: rtl/br_cond_eval.sv
// -----------------------------------------------------------------------------
// br_cond_eval
// Purely combinational branch-condition evaluator.
// Ports:
//   op   [2:0] in  : condition code (branch_pkg::br_op_e encoding)
//   n          in  : negative flag
//   z          in  : zero flag
//   take       out : 1 when the branch is taken
// Encodings outside the defined set evaluate as not taken.
// -----------------------------------------------------------------------------
module br_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] op,
    input  logic       n,
    input  logic       z,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        case (op)
            OP_BRN:  take = n;
            OP_BRZ:  take = z;
            OP_BRNZ: take = ~z;
            OP_BRP:  take = ~n & ~z;
            OP_JMP:  take = 1'b1;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
// Resolves branches against the N/Z flags, stalling for one cycle when the
// execute stage is writing the flags in the same cycle, and squashing the
// fetch/decode stages for FLUSH_CYCLES cycles after every redirect.
// Ports:
//   clk             in  : system clock, rising edge
//   rst             in  : asynchronous active-low reset
//   br_valid        in  : branch present in this stage
//   br_op     [2:0] in  : condition code
//   br_addr   [7:0] in  : branch target
//   IFgn / IFgz     in  : registered N / Z flags
//   NFCR / ZFCR     in  : N / Z flag write enables this cycle
//   br_taken        out : one-cycle redirect pulse (registered)
//   br_target [7:0] out : redirect address, held between pulses
//   stall           out : hold upstream (combinational, hazard cycle only)
//   flush           out : squash fetch/decode (registered)
//   br_count  [7:0] out : saturating taken-branch counter, only present when
//                         BRANCH_STATS_EN is defined
// -----------------------------------------------------------------------------
module branch_resolve
    import branch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       br_valid,
    input  logic [2:0] br_op,
    input  logic [7:0] br_addr,
    input  logic       IFgn,
    input  logic       IFgz,
    input  logic       NFCR,
    input  logic       ZFCR,
    output logic       br_taken,
    output logic [7:0] br_target,
    output logic       stall,
    output logic       flush
`ifdef BRANCH_STATS_EN
    ,
    output logic [7:0] br_count
`endif
);

    state_e     state_reg;
    logic [2:0] op_latched_reg;
    logic [7:0] addr_latched_reg;
    logic [1:0] flush_cnt_reg;
    logic       br_taken_reg;
    logic [7:0] br_target_reg;
    logic       flush_reg;

    logic       in_idle;
    logic       in_hold;
    logic       hold_req;
    logic [2:0] eval_op;
    logic       cond_take;
    logic       take_fire;

    assign in_idle  = (state_reg == ST_IDLE);
    assign in_hold  = (state_reg == ST_HOLD);

    // A conditional branch meeting a flag write must wait one cycle so it
    // sees the new flags instead of the stale registered ones.
    assign hold_req = in_idle & br_valid & (NFCR | ZFCR) & is_conditional(br_op);

    // Gated by rst so stall is forced low while reset is held.
    assign stall    = rst & hold_req;

    // Single evaluator: the latched op during HOLD, otherwise the live op.
    assign eval_op  = in_hold ? op_latched_reg : br_op;

    br_cond_eval u_cond (
        .op   (eval_op),
        .n    (IFgn),
        .z    (IFgz),
        .take (cond_take)
    );

    assign take_fire = (in_idle & br_valid & ~hold_req & cond_take)
                     | (in_hold & cond_take);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= ST_IDLE;
            op_latched_reg   <= 3'd0;
            addr_latched_reg <= 8'h00;
            flush_cnt_reg    <= 2'd0;
            br_taken_reg     <= 1'b0;
            br_target_reg    <= 8'h00;
            flush_reg        <= 1'b0;
        end else begin
            br_taken_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_HOLD: begin
                    if (take_fire) begin
                        br_taken_reg  <= 1'b1;
                        br_target_reg <= in_hold ? addr_latched_reg : br_addr;
                        flush_reg     <= 1'b1;
                        flush_cnt_reg <= FLUSH_CNT_LOAD;
                        state_reg     <= ST_FLUSH;
                    end else if (hold_req) begin
                        op_latched_reg   <= br_op;
                        addr_latched_reg <= br_addr;
                        state_reg        <= ST_HOLD;
                    end else if (in_hold) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    // br_valid is ignored here: the instruction is squashed.
                    if (flush_cnt_reg == 2'd1) begin
                        flush_cnt_reg <= 2'd0;
                        flush_reg     <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end else begin
                        flush_cnt_reg <= flush_cnt_reg - 2'd1;
                    end
                end
                default: begin
                    flush_cnt_reg <= 2'd0;
                    flush_reg     <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    assign br_taken  = br_taken_reg;
    assign br_target = br_target_reg;
    assign flush     = flush_reg;

`ifdef BRANCH_STATS_EN
    logic [7:0] br_count_reg;

    // Counts at the same edge that raises br_taken, so the count already
    // includes the branch while its pulse is visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_count_reg <= 8'h00;
        end else if (take_fire && (br_count_reg != 8'hFF)) begin
            br_count_reg <= br_count_reg + 8'h01;
        end
    end

    assign br_count = br_count_reg;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve
// Scoreboard bench: the driver applies one input set per cycle and pushes the
// outputs expected for that cycle (and any redirect target) into queues; a
// negedge monitor pops and compares. The reference model tracks the block as
// "cycles of flush left" plus "one branch waiting for new flags".
// -----------------------------------------------------------------------------
module tb_branch_resolve;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       br_valid = 1'b0;
    logic [2:0] br_op = 3'd0;
    logic [7:0] br_addr = 8'h00;
    logic       IFgn = 1'b0;
    logic       IFgz = 1'b0;
    logic       NFCR = 1'b0;
    logic       ZFCR = 1'b0;
    logic       br_taken;
    logic [7:0] br_target;
    logic       stall;
    logic       flush;
`ifdef BRANCH_STATS_EN
    logic [7:0] br_count;
`endif

    branch_resolve dut (
        .clk       (clk),
        .rst       (rst),
        .br_valid  (br_valid),
        .br_op     (br_op),
        .br_addr   (br_addr),
        .IFgn      (IFgn),
        .IFgz      (IFgz),
        .NFCR      (NFCR),
        .ZFCR      (ZFCR),
        .br_taken  (br_taken),
        .br_target (br_target),
        .stall     (stall),
        .flush     (flush)
`ifdef BRANCH_STATS_EN
        ,
        .br_count  (br_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       taken;
        logic [7:0] target;
        logic       stall;
        logic       flush;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] tgt_q[$];

    int vectors     = 0;
    int miscompares = 0;
    bit running     = 0;
    logic prev_taken = 1'b0;

    // Reference model state
    bit         m_taken      = 0;
    logic [7:0] m_target     = 8'h00;
    int         m_flush_left = 0;
    bit         m_pend       = 0;
    int         m_pend_op    = 0;
    logic [7:0] m_pend_addr  = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic bit cond_ok(input int op, input bit n, input bit z);
        case (op)
            1: return n;
            2: return z;
            3: return !z;
            4: return !n && !z;
            5: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // One clock cycle: drive inputs just after the edge, predict this cycle's
    // outputs, advance the model.
    task automatic cycle(input bit v, input int op, input logic [7:0] addr,
                         input bit n, input bit z, input bit nf, input bit zf,
                         input bit r);
        exp_t e;
        bit   nt;
        @(posedge clk);
        #1;
        rst      = r;
        br_valid = v;
        br_op    = 3'(op);
        br_addr  = addr;
        IFgn     = n;
        IFgz     = z;
        NFCR     = nf;
        ZFCR     = zf;
        if (!r) begin
            m_taken = 0; m_target = 8'h00; m_flush_left = 0; m_pend = 0;
            tgt_q.delete();
            e.taken = 1'b0; e.target = 8'h00; e.stall = 1'b0; e.flush = 1'b0;
        end else begin
            nt      = 0;
            e.taken = m_taken;
            e.target = m_target;
            e.flush = (m_flush_left > 0);
            e.stall = 1'b0;
            if (m_flush_left > 0) begin
                m_flush_left--;
            end else if (m_pend) begin
                m_pend = 0;
                if (cond_ok(m_pend_op, n, z)) begin
                    nt = 1; m_target = m_pend_addr;
                end
            end else if (v) begin
                if ((nf || zf) && op != 0 && op != 5) begin
                    e.stall = 1'b1;
                    m_pend = 1; m_pend_op = op; m_pend_addr = addr;
                end else if (cond_ok(op, n, z)) begin
                    nt = 1; m_target = addr;
                end
            end
            if (nt) begin
                m_flush_left = 2;
                tgt_q.push_back(m_target);
            end
            m_taken = nt;
        end
        exp_q.push_back(e);
        running = 1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(0, 0, 8'h00, 0, 0, 0, 0, 1);
    endtask

    // Monitor: compares every cycle, plus the redirect target on each pulse.
    always @(negedge clk) begin
        if (running) begin
            if (exp_q.size() == 0) begin
                chk("exp_queue_underflow", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("br_taken",  32'(br_taken),  32'(e.taken));
                chk("br_target", 32'(br_target), 32'(e.target));
                chk("stall",     32'(stall),     32'(e.stall));
                chk("flush",     32'(flush),     32'(e.flush));
            end
            if (br_taken === 1'b1) begin
                if (prev_taken === 1'b1) chk("taken_back_to_back", 1, 0);
                if (tgt_q.size() == 0) begin
                    chk("unexpected_taken", 1, 0);
                end else begin
                    logic [7:0] t;
                    t = tgt_q.pop_front();
                    chk("taken_target", 32'(br_target), 32'(t));
                end
                $display("taken target=%02h at %0t", br_target, $time);
            end
            prev_taken = br_taken;
        end
    end

    initial begin
        // Reset held: all outputs zero.
        cycle(0, 0, 8'h00, 0, 0, 0, 0, 0);
        cycle(1, 5, 8'hAA, 0, 0, 1, 1, 0);
        idle(2);

        // BRZ, no hazard: taken next cycle, two flush cycles, no stall.
        cycle(1, 2, 8'h3C, 0, 1, 0, 0, 1);
        idle(4);
        // BRN with flag write: one stall cycle, then resolves on new N.
        cycle(1, 1, 8'h55, 0, 0, 1, 0, 1);
        cycle(0, 0, 8'h00, 1, 0, 0, 0, 1);
        idle(4);
        // BRP with Z=1: nothing happens.
        cycle(1, 4, 8'h77, 0, 1, 0, 0, 1);
        idle(2);
        // JMP then BRZ inside the flush window: one redirect only.
        cycle(1, 5, 8'h10, 0, 0, 1, 1, 1);
        cycle(1, 2, 8'h20, 0, 1, 0, 0, 1);
        cycle(1, 2, 8'h21, 0, 1, 0, 0, 1);
        idle(3);
        // Reset during the second flush cycle.
        cycle(1, 5, 8'h99, 0, 0, 0, 0, 1);
        cycle(0, 0, 8'h00, 0, 0, 0, 0, 1);
        cycle(0, 0, 8'h00, 0, 0, 0, 0, 0);
        idle(4);
        // Undefined opcodes 6/7 never redirect.
        cycle(1, 6, 8'h66, 1, 1, 0, 0, 1);
        cycle(1, 7, 8'h67, 0, 0, 1, 0, 1);
        idle(3);

`ifdef BRANCH_STATS_EN
        cycle(0, 0, 8'h00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 260; i++) begin
            cycle(1, 5, 8'(i), 0, 0, 0, 0, 1);
            idle(2);
        end
        @(negedge clk);
        chk("br_count_saturated", 32'(br_count), 32'hFF);
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 1), int'($urandom_range(0, 7)), 8'($urandom),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 99) != 0));
        end
        idle(4);

        @(negedge clk);
        #1;
        running = 0;
        chk("exp_queue_drained", 32'(exp_q.size()), 0);
        chk("tgt_queue_drained", 32'(tgt_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
